pcie_wb_func_regs: RTL

- Wishbone slave responder on the PCIe subsystem's Wishbone master port (the per-function CYC / address / data bus the PCIe multifunction bridge drives toward user logic).
- Gives each PCIe function a small register window: ID, access counter, interrupt control and scratch registers.
- Serves single and linear incrementing-burst transfers with programmable wait states.
- Its per-function interrupt outputs feed back into the bridge's PCI interrupt request inputs.

---
 rtl/pcie_wb_func_regs_if.sv | 27 ++
 rtl/pcie_wb_func_regs.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pcie_wb_func_regs_if.sv
// Wishbone bus between the PCIe bridge master port and the per-function register block,
// plus the per-function interrupt levels returned to the bridge.
interface pcie_wb_func_regs_if;
    logic [7:0]  ix_wb_cyc;
    logic        ix_wb_stb;
    logic        ix_wb_we;
    logic [15:0] ix_wb_adr;
    logic [31:0] ix_wb_dat;
    logic [3:0]  ix_wb_sel;
    logic [2:0]  ix_wb_cti;
    logic [1:0]  ix_wb_bte;
    logic        ox_wb_ack;
    logic        ox_wb_err;
    logic [31:0] ox_wb_dat;
    logic [7:0]  ox_int_req;

    // Handshake: a beat completes on a rising edge where the addressed cyc bit is high and
    // ack or err is high; the master holds stb/we/adr/dat/sel stable until that edge.
    modport master (
        output ix_wb_cyc, ix_wb_stb, ix_wb_we, ix_wb_adr, ix_wb_dat, ix_wb_sel, ix_wb_cti, ix_wb_bte,
        input  ox_wb_ack, ox_wb_err, ox_wb_dat, ox_int_req
    );
    modport slave (
        input  ix_wb_cyc, ix_wb_stb, ix_wb_we, ix_wb_adr, ix_wb_dat, ix_wb_sel, ix_wb_cti, ix_wb_bte,
        output ox_wb_ack, ox_wb_err, ox_wb_dat, ox_int_req
    );
endinterface

// File: rtl/pcie_wb_func_regs.sv
// Per-function Wishbone register window (ID, ACK counter, interrupt enable, scratch) with
// programmable first-beat wait states and zero-wait linear incrementing bursts.
module pcie_wb_func_regs #(
    parameter int          NUM_FUNCS   = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] ID_TAG      = 16'hEC50
) (
    input  logic               ix_clk_125,
    input  logic               ix_rst,
    pcie_wb_func_regs_if.slave wb,
    output logic [1:0]         dbg_state
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_BURST} state_t;

    state_t      state;
    logic [7:0]  cyc_q;
    logic [2:0]  func_q;
    logic [13:0] addr_q;
    logic        we_q;
    logic        legal_q;
    logic        burst_q;
    logic [2:0]  wait_cnt;
    logic [31:0] dat_q;
    logic [31:0] ack_cnt [8];
    logic [7:0]  int_en;
    logic [31:0] scratch [8][5];

    logic        cyc_live;
    logic        start_legal;
    logic [2:0]  start_func;
    logic        ack;
    logic        in_win;
    logic [2:0]  scr_idx;
    logic        unused_adr;

    assign unused_adr = ^wb.ix_wb_adr[1:0];

    // Abort tracking: the transfer stays alive only while a latched cyc bit is still high.
    assign cyc_live = |(wb.ix_wb_cyc & cyc_q);

    always_comb begin
        start_func = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (wb.ix_wb_cyc[i]) start_func = 3'(i);
        end
    end

    assign start_legal = $onehot(wb.ix_wb_cyc) && (int'(start_func) < NUM_FUNCS);

    // Bursts are only ever entered for legal transfers, so BURST needs no legality term.
    assign ack = cyc_live && ((state == ST_RESP && legal_q) || (state == ST_BURST && wb.ix_wb_stb));
    assign wb.ox_wb_ack  = ack;
    assign wb.ox_wb_err  = cyc_live && state == ST_RESP && !legal_q;
    assign wb.ox_wb_dat  = ack ? dat_q : 32'd0;
    assign wb.ox_int_req = int_en;
    assign dbg_state     = state;

    assign in_win  = (addr_q[13:3] == 11'd0);
    assign scr_idx = addr_q[2:0] - 3'd3;

    function automatic logic [31:0] read_word(input logic [2:0] f, input logic [13:0] a,
                                              input logic [31:0] cnt);
        logic [31:0] v;
        logic [2:0]  s;
        v = 32'd0;
        s = a[2:0] - 3'd3;
        if (a[13:3] == 11'd0) begin
            case (a[2:0])
                3'd0:    v = {ID_TAG, 13'd0, f};
                3'd1:    v = cnt;
                3'd2:    v = {31'd0, int_en[f]};
                default: v = scratch[f][s];
            endcase
        end
        return v;
    endfunction

    always_ff @(posedge ix_clk_125 or posedge ix_rst) begin
        if (ix_rst) begin
            state    <= ST_IDLE;
            cyc_q    <= 8'd0;
            func_q   <= 3'd0;
            addr_q   <= 14'd0;
            we_q     <= 1'b0;
            legal_q  <= 1'b0;
            burst_q  <= 1'b0;
            wait_cnt <= 3'd0;
            dat_q    <= 32'd0;
            int_en   <= 8'd0;
            for (int f = 0; f < 8; f++) begin
                ack_cnt[f] <= 32'd0;
                for (int w = 0; w < 5; w++) scratch[f][w] <= 32'd0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|wb.ix_wb_cyc && wb.ix_wb_stb) begin
                        cyc_q   <= wb.ix_wb_cyc;
                        func_q  <= start_func;
                        addr_q  <= wb.ix_wb_adr[15:2];
                        we_q    <= wb.ix_wb_we;
                        legal_q <= start_legal;
                        burst_q <= start_legal && wb.ix_wb_cti == 3'b010 && wb.ix_wb_bte == 2'b00;
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                            dat_q <= read_word(start_func, wb.ix_wb_adr[15:2], ack_cnt[start_func]);
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= 3'(WAIT_STATES);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!cyc_live) begin
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                        if (wait_cnt == 3'd1) begin
                            state <= ST_RESP;
                            dat_q <= read_word(func_q, addr_q, ack_cnt[func_q]);
                        end
                    end
                end
                ST_RESP: begin
                    state <= (cyc_live && legal_q && burst_q) ? ST_BURST : ST_IDLE;
                end
                ST_BURST: begin
                    if (!cyc_live || (wb.ix_wb_stb && wb.ix_wb_cti == 3'b111)) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // Every ACKed beat commits, counts, advances the address and prefetches the next word;
            // the prefetch sees the post-increment count so a burst over W1 reads consistently.
            if (ack) begin
                ack_cnt[func_q] <= ack_cnt[func_q] + 32'd1;
                addr_q          <= addr_q + 14'd1;
                dat_q           <= read_word(func_q, addr_q + 14'd1, ack_cnt[func_q] + 32'd1);
                if (we_q && in_win) begin
                    if (addr_q[2:0] == 3'd2) begin
                        if (wb.ix_wb_sel[0]) int_en[func_q] <= wb.ix_wb_dat[0];
                    end else if (addr_q[2:0] >= 3'd3) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wb.ix_wb_sel[b])
                                scratch[func_q][scr_idx][8*b +: 8] <= wb.ix_wb_dat[8*b +: 8];
                        end
                    end
                end
            end
        end
    end
endmodule
